uart_rx_datapath: RTL

//  Serial-in, parallel-out UART receiver. It is the far-end counterpart of the TX datapath.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rx_sync2.sv | 34 +++
 rtl/uart_rx_datapath.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions: receiver FSM state type, frame geometry and the
//   line levels of the 8N1 frame. Imported by the UART RX datapath.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_sync2.sv
// -----------------------------------------------------------------------------
// rx_sync2
//   Two-flop synchronizer for a single asynchronous input. The reset value is
//   a parameter so the flops can be preset to the input's idle level.
// Ports
//   clk    in  1  system clock, rising edge
//   reset  in  1  asynchronous, active-low reset
//   d      in  1  asynchronous input
//   q      out 1  input synchronized to clk (2-cycle latency)
// -----------------------------------------------------------------------------
module rx_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_datapath.sv
// -----------------------------------------------------------------------------
// uart_rx_datapath
//   8N1 UART receiver. rx_in is synchronized, the start bit is validated at
//   mid-bit, data bits are sampled at mid-bit LSB-first, and the stop bit is
//   checked at mid-stop. Good bytes are presented with a valid/ack handshake;
//   a bad stop bit pulses frame_error, and a good byte arriving while the
//   previous one is still unconsumed pulses overrun and is dropped.
// Ports
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-low reset
//   rx_in        in   1  serial line, idle high, asynchronous to clk
//   rx_ack       in   1  consumer has taken rx_data; clears data_valid
//   rx_data      out  8  last good received byte
//   data_valid   out  1  rx_data holds an unconsumed byte
//   frame_error  out  1  1-cycle pulse, stop bit sampled low
//   overrun      out  1  1-cycle pulse, good byte dropped (no ack)
//   rx_busy      out  1  receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx_datapath
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 seen_high;

    logic                 stop_sample;
    logic                 load_byte;
    logic                 set_overrun;
    logic                 set_frame_error;

    rx_sync2 #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_s)
    );

    // -------------------------------------------------------------------------
    // Frame FSM. After a frame ends (or after a break), a new start is only
    // accepted once the line has been seen high in IDLE, so a held-low line
    // produces a single framing error instead of a stream of frames.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            seen_high <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (rx_s == IDLE_LEVEL) begin
                        seen_high <= 1'b1;
                    end else if (seen_high) begin
                        state     <= START;
                        seen_high <= 1'b0;
                    end
                end

                START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        if (rx_s == START_BIT) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            // Too short to be a start bit; the line is high again.
                            state     <= IDLE;
                            seen_high <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        clk_cnt   <= '0;
                        state     <= IDLE;
                        seen_high <= (rx_s == STOP_BIT);
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign stop_sample = (state == STOP) && (clk_cnt == CNT_LAST);

    // -------------------------------------------------------------------------
    // Completion decision on the mid-stop sampling edge. An ack arriving on the
    // same edge frees the holding register, so the new byte is accepted.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        load_byte       = 1'b0;
        set_overrun     = 1'b0;
        set_frame_error = 1'b0;
        if (stop_sample) begin
            if (rx_s == STOP_BIT) begin
                if (!data_valid || rx_ack) begin
                    load_byte = 1'b1;
                end else begin
                    set_overrun = 1'b1;
                end
            end else begin
                set_frame_error = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data     <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= set_frame_error;
            overrun     <= set_overrun;
            if (load_byte) begin
                rx_data    <= shreg;
                data_valid <= 1'b1;
            end else if (rx_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule
